// File: rtl/proj_errmon_if.sv
// Status bundle between the lane bench and the error monitor: lane counters/flags in,
// accumulated error status out.
interface proj_errmon_if #(
    parameter int L  = 4,
    parameter int EW = 8,
    parameter int LW = 2,
    parameter int TW = 16
);
    logic              clr;
    logic [L*EW-1:0]   errcntrs;
    logic [L-1:0]      errflgs;
    logic [TW-1:0]     total;
    logic [L-1:0]      sticky;
    logic              firstvld;
    logic [LW-1:0]     firstlane;
    logic              alarm;

    modport master (
        output clr, errcntrs, errflgs,
        input  total, sticky, firstvld, firstlane, alarm
    );

    modport slave (
        input  clr, errcntrs, errflgs,
        output total, sticky, firstvld, firstlane, alarm
    );
endinterface

// File: rtl/proj_errmon.sv
// Lane error monitor: saturating total of lane counter increments, per-lane sticky flags,
// first-failing-lane capture and a latched threshold alarm.
module proj_errmon #(
    parameter int L   = 4,
    parameter int EW  = 8,
    parameter int LW  = 2,
    parameter int TW  = 16,
    parameter int THR = 1
) (
    input  logic         clk,
    input  logic         rst,
    proj_errmon_if.slave mon
);
    localparam int SW = EW + LW;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        TRIP  = 2'd2
    } state_t;

    state_t          state;
    logic [EW-1:0]   prev [L];
    logic [TW-1:0]   total_r;
    logic [L-1:0]    sticky_r;
    logic            firstvld_r;
    logic [LW-1:0]   firstlane_r;
    logic            alarm_r;

    logic [EW-1:0]   delta [L];
    logic [L-1:0]    hit;
    logic [SW-1:0]   lane_sum;
    logic [LW-1:0]   first_idx;
    logic            found;
    logic [TW-1:0]   next_total;

    // Widen to TW+1 so the carry out shows overflow; clamp instead of wrapping.
    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] acc,
                                              input logic [SW-1:0] inc);
        logic [TW:0] wide;
        wide = {1'b0, acc} + (TW+1)'(inc);
        return wide[TW] ? {TW{1'b1}} : wide[TW-1:0];
    endfunction

    always_comb begin
        lane_sum  = '0;
        hit       = '0;
        first_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < L; i++) begin
            // Modular difference absorbs a lane counter wrapping between samples.
            delta[i] = mon.errcntrs[i*EW +: EW] - prev[i];
            hit[i]   = (delta[i] != '0) | mon.errflgs[i];
            lane_sum = lane_sum + SW'(delta[i]);
            if (hit[i] && !found) begin
                first_idx = LW'(i);
                found     = 1'b1;
            end
        end
        next_total = sat_add(total_r, lane_sum);
    end

    always_ff @(posedge clk) begin
        if (rst || mon.clr) begin
            state       <= PRIME;
            total_r     <= '0;
            sticky_r    <= '0;
            firstvld_r  <= 1'b0;
            firstlane_r <= '0;
            alarm_r     <= 1'b0;
            for (int i = 0; i < L; i++) prev[i] <= '0;
        end else begin
            case (state)
                PRIME: begin
                    // Take a baseline of whatever the lanes hold; nothing is counted yet.
                    for (int i = 0; i < L; i++) prev[i] <= mon.errcntrs[i*EW +: EW];
                    state <= RUN;
                end
                RUN, TRIP: begin
                    for (int i = 0; i < L; i++) prev[i] <= mon.errcntrs[i*EW +: EW];
                    total_r  <= next_total;
                    sticky_r <= sticky_r | hit;
                    if (!firstvld_r && (hit != '0)) begin
                        firstvld_r  <= 1'b1;
                        firstlane_r <= first_idx;
                    end
                    if (next_total >= TW'(THR)) begin
                        alarm_r <= 1'b1;
                        state   <= TRIP;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

    assign mon.total     = total_r;
    assign mon.sticky    = sticky_r;
    assign mon.firstvld  = firstvld_r;
    assign mon.firstlane = firstlane_r;
    assign mon.alarm     = alarm_r;
endmodule

// File: tb/tb_proj_errmon.sv
// Bench for proj_errmon: directed scenarios plus randomized lane activity, every edge
// compared against an arithmetic reference model of the monitor.
module tb_proj_errmon;
    localparam int L   = 4;
    localparam int EW  = 8;
    localparam int LW  = 2;
    localparam int TW  = 16;
    localparam int THR = 1;
    localparam int TMAX = (1 << TW) - 1;

    logic clk;
    logic rst;

    proj_errmon_if #(.L(L), .EW(EW), .LW(LW), .TW(TW)) mon ();

    proj_errmon #(.L(L), .EW(EW), .LW(LW), .TW(TW), .THR(THR)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int       m_prev [L];
    bit       m_primed;
    int       m_total;
    bit [L-1:0] m_sticky;
    bit       m_fv;
    int       m_fl;
    bit       m_alarm;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lane_val(input int i);
        return int'(mon.errcntrs[i*EW +: EW]);
    endfunction

    task automatic model_clear();
        m_primed = 0;
        m_total  = 0;
        m_sticky = '0;
        m_fv     = 0;
        m_fl     = 0;
        m_alarm  = 0;
        for (int i = 0; i < L; i++) m_prev[i] = 0;
    endtask

    // One clock edge of the monitor as described by its rules, in plain arithmetic.
    task automatic model_edge();
        int sum;
        int d;
        bit [L-1:0] hits;
        if (rst || mon.clr) begin
            model_clear();
        end else if (!m_primed) begin
            for (int i = 0; i < L; i++) m_prev[i] = lane_val(i);
            m_primed = 1;
        end else begin
            sum  = 0;
            hits = '0;
            for (int i = 0; i < L; i++) begin
                d = (lane_val(i) - m_prev[i] + (1 << EW)) % (1 << EW);
                sum += d;
                if (d != 0 || mon.errflgs[i]) hits[i] = 1'b1;
                m_prev[i] = lane_val(i);
            end
            m_total = (m_total + sum > TMAX) ? TMAX : m_total + sum;
            m_sticky |= hits;
            if (!m_fv && hits != '0) begin
                m_fv = 1;
                for (int i = L - 1; i >= 0; i--) if (hits[i]) m_fl = i;
            end
            if (m_total >= THR) m_alarm = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("total",     mon.total,     64'(m_total));
        check_eq("sticky",    mon.sticky,    64'(m_sticky));
        check_eq("firstvld",  mon.firstvld,  64'(m_fv));
        check_eq("firstlane", mon.firstlane, 64'(m_fl));
        check_eq("alarm",     mon.alarm,     64'(m_alarm));
    endtask

    task automatic set_lane(input int i, input int v);
        mon.errcntrs[i*EW +: EW] = EW'(v);
    endtask

    task automatic set_lanes(input int a, input int b, input int c, input int d);
        set_lane(0, a); set_lane(1, b); set_lane(2, c); set_lane(3, d);
    endtask

    // Clear, then one priming edge, leaving lanes at the given values.
    task automatic restart(input int a, input int b, input int c, input int d);
        set_lanes(a, b, c, d);
        mon.errflgs = '0;
        mon.clr = 1'b1;
        tick();
        mon.clr = 1'b0;
        tick();
    endtask

    task automatic clear_midrun(input bit use_rst);
        restart(0, 0, 0, 0);
        set_lanes(5, 0, 7, 0);
        tick();
        check_eq("midrun_total12", mon.total, 64'd12);
        if (use_rst) rst = 1'b1; else mon.clr = 1'b1;
        tick();
        rst = 1'b0; mon.clr = 1'b0;
        check_eq("clr_total0", mon.total, 64'd0);
        check_eq("clr_alarm0", mon.alarm, 64'd0);
        check_eq("clr_sticky0", mon.sticky, 64'd0);
        tick();
        check_eq("prime_no_accum", mon.total, 64'd0);
        set_lane(0, 6);
        tick();
        check_eq("after_clr_total", mon.total, 64'd1);
        check_eq("after_clr_first", mon.firstlane, 64'd0);
        check_eq("after_clr_fv", mon.firstvld, 64'd1);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        mon.clr = 1'b0;
        mon.errcntrs = '0;
        mon.errflgs = '0;
        model_clear();

        // Reset and quiet run
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("quiet_total", mon.total, 64'd0);
        check_eq("quiet_fv", mon.firstvld, 64'd0);

        // Single lane stepping
        for (int v = 1; v <= 3; v++) begin
            set_lane(2, v);
            tick();
            check_eq("single_total", mon.total, 64'(v));
        end
        check_eq("single_sticky", mon.sticky, 64'b0100);
        check_eq("single_first", mon.firstlane, 64'd2);
        check_eq("single_alarm", mon.alarm, 64'd1);

        // Simultaneous lanes 0 and 3
        restart(0, 0, 0, 0);
        set_lanes(1, 0, 0, 1);
        tick();
        check_eq("simul_total", mon.total, 64'd2);
        check_eq("simul_first", mon.firstlane, 64'd0);
        check_eq("simul_sticky", mon.sticky, 64'b1001);

        // Counter wrap, then a flag with static counters
        restart(0, 8'hFE, 0, 0);
        set_lane(1, 8'h01);
        tick();
        check_eq("wrap_total", mon.total, 64'd3);
        restart(0, 0, 0, 0);
        mon.errflgs = 4'b0001;
        tick();
        mon.errflgs = '0;
        check_eq("flag_sticky", mon.sticky, 64'b0001);
        check_eq("flag_total", mon.total, 64'd0);
        check_eq("flag_fv", mon.firstvld, 64'd1);

        // Clear / reset mid-run
        clear_midrun(1'b0);
        clear_midrun(1'b1);

        // Saturation: all lanes advance every cycle
        restart(0, 0, 0, 0);
        for (int n = 1; n <= 16500; n++) begin
            for (int i = 0; i < L; i++) set_lane(i, n & 8'hFF);
            tick();
        end
        check_eq("sat_total", mon.total, 64'hFFFF);
        check_eq("sat_alarm", mon.alarm, 64'd1);

        // Randomized lane activity with occasional clr/rst
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < L; i++) begin
                r = $urandom_range(0, 19);
                if (r >= 12 && r < 19) set_lane(i, lane_val(i) + 1);
                else if (r == 19) set_lane(i, $urandom_range(0, 255));
            end
            mon.errflgs = ($urandom_range(0, 15) == 0) ? L'($urandom) : '0;
            mon.clr = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        mon.clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
